// File: rtl/angle_disp_pkg.sv
// Shared constants, FSM state type and the double-dabble nibble adjust
// used by the angle-to-degrees display controller.
package angle_disp_pkg;

  localparam int COUNTS_PER_REV = 1006;
  localparam int DEG_PER_REV    = 360;
  localparam int MAX_ANGLE      = 1005;
  localparam int DIV_STEPS      = 21;
  localparam int DABBLE_STEPS   = 9;
  localparam int NUM_DIGITS     = 3;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DABBLE,
    DONE
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [11:0] dabbleAdjust(input logic [11:0] value);
    logic [11:0] result;
    result = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (value[4*i +: 4] >= 4'd5) begin
        result[4*i +: 4] = value[4*i +: 4] + 4'd3;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// A blanked digit, or a non-decimal nibble, turns every segment off.
module bcd_to_7seg (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = 7'b1111111;
    if (!blank_i) begin
      unique case (nibble_i)
        4'd0:    seg_n_o = 7'b1000000;
        4'd1:    seg_n_o = 7'b1111001;
        4'd2:    seg_n_o = 7'b0100100;
        4'd3:    seg_n_o = 7'b0110000;
        4'd4:    seg_n_o = 7'b0011001;
        4'd5:    seg_n_o = 7'b0010010;
        4'd6:    seg_n_o = 7'b0000010;
        4'd7:    seg_n_o = 7'b1111000;
        4'd8:    seg_n_o = 7'b0000000;
        4'd9:    seg_n_o = 7'b0010000;
        default: seg_n_o = 7'b1111111;
      endcase
    end
  end

endmodule

// File: rtl/angle_display_ctrl.sv
// Samples the encoder angle, converts it to whole degrees and BCD with a
// sequential divider plus double-dabble, and scans a 3-digit 7-seg display.
module angle_display_ctrl
  import angle_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1_000_000,
  parameter int SCAN_DIV    = 50_000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] angle,
  input  logic        hold,
  output logic [11:0] bcd,
  output logic        valid,
  output logic        busy,
  output logic        range_err,
  output logic [6:0]  seg_n,
  output logic [2:0]  dig_n
);

  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic [REF_W-1:0]  refreshCnt_q, refreshCnt_d;
  logic              tick;
  state_t            state_q, state_d;
  logic [4:0]        stepCnt_q, stepCnt_d;
  logic [20:0]       num_q, num_d;
  logic [10:0]       rem_q, rem_d;
  logic [8:0]        quot_q, quot_d;
  logic [11:0]       work_q, work_d;
  logic              err_q, err_d;
  logic [11:0]       bcd_q, bcd_d;
  logic              rangeErr_q, rangeErr_d;
  logic              valid_q, valid_d;
  logic [11:0]       trial;
  logic [11:0]       adjusted;
  logic [9:0]        clampA;
  logic [20:0]       aExt;
  logic [SCAN_W-1:0] scanCnt_q, scanCnt_d;
  logic [1:0]        digIdx_q, digIdx_d;
  logic [6:0]        segN_q, segN_d;
  logic [2:0]        digN_q, digN_d;
  logic [3:0]        selNibble;
  logic              selBlank;

  always_comb begin
    tick         = (refreshCnt_q == REF_W'(REFRESH_DIV - 1));
    refreshCnt_d = tick ? '0 : refreshCnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refreshCnt_q <= '0;
    end else begin
      refreshCnt_q <= refreshCnt_d;
    end
  end

  // Conversion sequencer: clamp and scale, restoring divide, then double-dabble.
  always_comb begin
    state_d    = state_q;
    stepCnt_d  = stepCnt_q;
    num_d      = num_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    work_d     = work_q;
    err_d      = err_q;
    bcd_d      = bcd_q;
    rangeErr_d = rangeErr_q;
    valid_d    = 1'b0;
    trial      = {rem_q, num_q[20]};
    adjusted   = dabbleAdjust(work_q);
    clampA     = (angle > 12'(MAX_ANGLE)) ? 10'(MAX_ANGLE) : angle[9:0];
    aExt       = {11'd0, clampA};

    unique case (state_q)
      IDLE: begin
        if (tick && !hold) begin
          err_d     = (angle > 12'(MAX_ANGLE));
          num_d     = (aExt << 8) + (aExt << 6) + (aExt << 5) + (aExt << 3);
          rem_d     = '0;
          quot_d    = '0;
          work_d    = '0;
          stepCnt_d = '0;
          state_d   = DIV;
        end
      end
      DIV: begin
        num_d = {num_q[19:0], 1'b0};
        if (trial >= 12'(COUNTS_PER_REV)) begin
          rem_d  = 11'(trial - 12'(COUNTS_PER_REV));
          quot_d = {quot_q[7:0], 1'b1};
        end else begin
          rem_d  = trial[10:0];
          quot_d = {quot_q[7:0], 1'b0};
        end
        if (stepCnt_q == 5'(DIV_STEPS - 1)) begin
          stepCnt_d = '0;
          state_d   = DABBLE;
        end else begin
          stepCnt_d = stepCnt_q + 5'd1;
        end
      end
      DABBLE: begin
        work_d = 12'({adjusted, quot_q[8]});
        quot_d = {quot_q[7:0], 1'b0};
        if (stepCnt_q == 5'(DABBLE_STEPS - 1)) begin
          stepCnt_d = '0;
          state_d   = DONE;
        end else begin
          stepCnt_d = stepCnt_q + 5'd1;
        end
      end
      DONE: begin
        bcd_d      = work_q;
        rangeErr_d = err_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      stepCnt_q  <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      work_q     <= '0;
      err_q      <= 1'b0;
      bcd_q      <= '0;
      rangeErr_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stepCnt_q  <= stepCnt_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      work_q     <= work_d;
      err_q      <= err_d;
      bcd_q      <= bcd_d;
      rangeErr_q <= rangeErr_d;
      valid_q    <= valid_d;
    end
  end

  // Digit scan: segments and enable are computed for the upcoming index so both flip together.
  always_comb begin
    scanCnt_d = scanCnt_q + 1'b1;
    digIdx_d  = digIdx_q;
    if (scanCnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scanCnt_d = '0;
      digIdx_d  = (digIdx_q == 2'd2) ? 2'd0 : digIdx_q + 2'd1;
    end
    selNibble = bcd_q[3:0];
    selBlank  = 1'b0;
    digN_d    = 3'b110;
    unique case (digIdx_d)
      2'd1: begin
        selNibble = bcd_q[7:4];
        selBlank  = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
        digN_d    = 3'b101;
      end
      2'd2: begin
        selNibble = bcd_q[11:8];
        selBlank  = BLANK_LZ && (bcd_q[11:8] == 4'd0);
        digN_d    = 3'b011;
      end
      default: begin
        selNibble = bcd_q[3:0];
        selBlank  = 1'b0;
        digN_d    = 3'b110;
      end
    endcase
  end

  bcd_to_7seg u_bcd_to_7seg (
    .nibble_i (selNibble),
    .blank_i  (selBlank),
    .seg_n_o  (segN_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scanCnt_q <= '0;
      digIdx_q  <= 2'd0;
      segN_q    <= 7'b1000000;
      digN_q    <= 3'b110;
    end else begin
      scanCnt_q <= scanCnt_d;
      digIdx_q  <= digIdx_d;
      segN_q    <= segN_d;
      digN_q    <= digN_d;
    end
  end

  assign bcd       = bcd_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign range_err = rangeErr_q;
  assign seg_n     = segN_q;
  assign dig_n     = digN_q;

endmodule

// File: tb/tb_angle_display_ctrl.sv
// Scoreboard bench for angle_display_ctrl: stimulus queues expected results,
// a negedge monitor compares them, along with latency, busy length and scan.
module tb_angle_display_ctrl;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic        err;
    logic [11:0] bcd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] angle;
  logic        hold;
  logic [11:0] bcd;
  logic        valid;
  logic        busy;
  logic        range_err;
  logic [6:0]  seg_n;
  logic [2:0]  dig_n;

  int   checks = 0;
  int   failures = 0;
  int   edges = 0;
  int   lastTickEdge = 0;
  int   validCount = 0;
  int   busyRun = 0;
  logic prevValid = 1'b0;
  int   tbRefCnt = 0;
  int   tbScanCnt = 0;
  int   tbDigIdx = 0;
  exp_t expQ[$];

  angle_display_ctrl #(
    .REFRESH_DIV (64),
    .SCAN_DIV    (4),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .angle     (angle),
    .hold      (hold),
    .bcd       (bcd),
    .valid     (valid),
    .busy      (busy),
    .range_err (range_err),
    .seg_n     (seg_n),
    .dig_n     (dig_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Reference refresh tick and digit scan, built straight from the timing description.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tbRefCnt  <= 0;
      tbScanCnt <= 0;
      tbDigIdx  <= 0;
    end else begin
      if (tbRefCnt == 63) begin
        tbRefCnt     <= 0;
        lastTickEdge <= edges + 1;
      end else begin
        tbRefCnt <= tbRefCnt + 1;
      end
      if (tbScanCnt == 3) begin
        tbScanCnt <= 0;
        tbDigIdx  <= (tbDigIdx == 2) ? 0 : tbDigIdx + 1;
      end else begin
        tbScanCnt <= tbScanCnt + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timed out at t=%0t", name, $time);
  endtask

  task automatic waitTick();
    int start = lastTickEdge;
    int n = 0;
    while (lastTickEdge == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (lastTickEdge == start) reportTimeout("wait_tick");
  endtask

  task automatic waitValid();
    int start = validCount;
    int n = 0;
    while (validCount == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (validCount == start) reportTimeout("wait_valid");
  endtask

  task automatic applyStimulus(input logic [11:0] ang, input logic [11:0] expBcd, input logic expErr);
    exp_t e;
    @(negedge clk);
    angle = ang;
    waitTick();
    e.err = expErr;
    e.bcd = expBcd;
    expQ.push_back(e);
    waitValid();
  endtask

  // Monitor: pops one expectation per valid pulse and tracks busy run length.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busyRun   = 0;
      prevValid = 1'b0;
    end else begin
      if (valid) begin
        validCount++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_valid bcd=%0h range_err=%0b at t=%0t", bcd, range_err, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("bcd", int'(bcd), int'(e.bcd));
          checkOutput("range_err", int'(range_err), int'(e.err));
          checkOutput("latency", edges - lastTickEdge, 31);
        end
        checkOutput("valid_single_pulse", int'(prevValid), 0);
      end
      if (busy) begin
        busyRun++;
      end else if (busyRun != 0) begin
        checkOutput("busy_length", busyRun, 31);
        busyRun = 0;
      end
      prevValid = valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    angle = 12'd0;
    hold  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_bcd", int'(bcd), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_range_err", int'(range_err), 0);
    checkOutput("reset_dig_n", int'(dig_n), 3'b110);
    checkOutput("reset_seg_n", int'(seg_n), int'(SEG_ZERO));
    @(negedge clk);
    #2 reset = 1'b0;

    applyStimulus(12'd0, 12'h000, 1'b0);
    applyStimulus(12'd503, 12'h180, 1'b0);
    applyStimulus(12'd1005, 12'h359, 1'b0);
    applyStimulus(12'd2000, 12'h359, 1'b1);
    applyStimulus(12'd1, 12'h000, 1'b0);

    // Result 001: units shows "1", tens and hundreds blank.
    applyStimulus(12'd3, 12'h001, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      checkOutput("scan_dig_n", int'(dig_n), int'(3'b111 & ~(3'b001 << tbDigIdx)));
      checkOutput("scan_seg_n", int'(seg_n), (tbDigIdx == 0) ? int'(SEG_ONE) : int'(SEG_BLANK));
      @(negedge clk);
    end

    applyStimulus(12'd503, 12'h180, 1'b0);
    @(negedge clk);
    hold  = 1'b1;
    angle = 12'd1005;
    waitTick();
    waitTick();
    checkOutput("hold_bcd", int'(bcd), 12'h180);
    checkOutput("hold_range_err", int'(range_err), 0);
    hold = 1'b0;
    applyStimulus(12'd1005, 12'h359, 1'b0);

    @(negedge clk);
    angle = 12'd503;
    waitTick();
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_valid", int'(valid), 0);
    checkOutput("abort_bcd", int'(bcd), 0);
    checkOutput("abort_dig_n", int'(dig_n), 3'b110);
    checkOutput("abort_seg_n", int'(seg_n), int'(SEG_ZERO));
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    applyStimulus(12'd503, 12'h180, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/angle_display_ctrl.md
Name: angle_display_ctrl

Overview:
- Periodically samples the 12-bit encoder angle and converts it to whole degrees (deg = 360*angle/1006, truncated).
- Converts the degrees to 3-digit BCD using a sequential restoring divider followed by sequential double-dabble.
- Drives a time-multiplexed 3-digit common-anode 7-segment display.
- Sits between the encoder position counter and the board display pins.

Parameters:
- REFRESH_DIV, 1_000_000: clk cycles between sample ticks; minimum 64.
- SCAN_DIV, 50_000: clk cycles each digit stays enabled; minimum 2.
- BLANK_LZ, 1: 1 = blank leading zeros on hundreds and tens digits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- angle  in  12  encoder count; valid range 0..1005
- hold  in  1  1 = suppress new samples; an in-flight conversion still completes
- bcd  out  12  registered result {hundreds, tens, units}
- valid  out  1  one-clk pulse when bcd updates
- busy  out  1  high while a conversion is in progress
- range_err  out  1  registered with bcd; 1 = sampled angle was >1005
- seg_n  out  7  active-low segments, bit order {g,f,e,d,c,b,a}
- dig_n  out  3  active-low digit enables; bit0 = units, bit2 = hundreds

Behaviour:
- Reset values: bcd=0, valid=0, busy=0, range_err=0, refresh and scan counters=0, state=IDLE, digit index=0, so dig_n=3'b110 and seg_n=7'b1000000 ("0").
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick is high for 1 cycle when the count equals REFRESH_DIV-1.
- FSM states and transitions:
  - IDLE: on tick && !hold:
    - capture a = (angle>1005) ? 1005 : angle, and err = (angle>1005);
    - load the 21-bit numerator 360*a, computed as (a<<8)+(a<<6)+(a<<5)+(a<<3);
    - go to DIV.
  - DIV: 21 cycles of restoring division by 1006, MSB first. The remainder register is 11 bits.
  - DABBLE: 9 cycles of double-dabble on the 9-bit quotient. Per cycle, add 3 to each nibble that is >=5, then shift left one bit, inserting the next quotient bit MSB-first.
  - DONE: 1 cycle. Write bcd and range_err, assert valid for that cycle, return to IDLE.
- Latency: the edge that samples tick leads to valid high exactly 31 cycles later (21 DIV + 9 DABBLE + 1 DONE).
- busy is high in DIV, DABBLE and DONE.
- tick while busy: dropped, no queueing. tick with hold=1: dropped.
- Quotient is guaranteed <=359, so hundreds <=3 and no overflow is possible.
- bcd and range_err hold their values between conversions.
- Scan counter:
  - Counts 0..SCAN_DIV-1.
  - On wrap, digit index advances 0→1→2→0.
  - dig_n is one-hot low at the selected index.
- seg_n is the pattern for the selected nibble of the registered bcd. Both seg_n and dig_n are registered and change on the same edge.
- Blanking when BLANK_LZ=1:
  - hundreds blank if hundreds==0;
  - tens blank if hundreds==0 && tens==0;
  - units never blank.
  - A blanked digit drives seg_n=7'b1111111; dig_n is unchanged.
- Nibbles 10..15 cannot occur; if they do, the decoder outputs all-off.
- Reset mid-conversion: all state clears immediately (asynchronous), no valid is produced, and the display shows "0" on units.

Decomposition:
- Package angle_disp_pkg holds:
  - COUNTS_PER_REV=1006, DEG_PER_REV=360, MAX_ANGLE=1005;
  - DIV_STEPS=21, DABBLE_STEPS=9, NUM_DIGITS=3;
  - enum state_t {IDLE, DIV, DABBLE, DONE}.
- One sub-module, bcd_to_7seg: 4-bit nibble + blank in, 7-bit active-low segments out, combinational.

Test Plan (REFRESH_DIV=64, SCAN_DIV=4):
- Reset released, angle=0 → all outputs at reset values; first valid 31 cycles after the first tick edge, with bcd=12'h000 and range_err=0.
- angle=503 → bcd=12'h180, range_err=0; busy high for exactly 31 cycles; valid is a single-cycle pulse.
- angle=1005 → bcd=12'h359. Then angle=2000 → bcd=12'h359, range_err=1. Then angle=1 → bcd=12'h000, range_err=0.
- angle=3 (result 001), BLANK_LZ=1 → over 12 cycles dig_n cycles 110, 101, 011, each for 4 cycles; seg_n = units "1" (7'b1111001), then 7'b1111111 twice.
- hold=1 across two ticks with angle changed 503→1005 → no valid and bcd stays 12'h180. Release hold → next tick yields 12'h359.
- Assert reset 10 cycles into DIV → busy=0 at once; no valid pulse after release until the next tick conversion completes.
